// File: rtl/id_ex_operand_stage.sv
// ID/EX operand stage: decodes the IF/ID instruction, fetches operands with a write-back bypass,
// detects load-use hazards and registers the result into the ID/EX pipeline register.
module id_ex_operand_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        inValid,
    output logic        inReady,
    input  logic [31:0] inInstr,
    input  logic [31:0] inPc,
    output logic [4:0]  adr1,
    output logic [4:0]  adr2,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    input  logic        wbWrite,
    input  logic [4:0]  wbAdr,
    input  logic [31:0] wbData,
    output logic        outValid,
    input  logic        outReady,
    output logic [31:0] outPc,
    output logic [31:0] outInstr,
    output logic [31:0] outA,
    output logic [31:0] outB,
    output logic [31:0] outImm,
    output logic [4:0]  outRs,
    output logic [4:0]  outRt,
    output logic [4:0]  outRd,
    output logic        outRegWrite,
    output logic        outMemRead,
    output logic        outMemWrite,
    output logic [15:0] stallCount
);

    typedef enum logic {EMPTY, FULL} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] imm;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
    } id_ex_t;

    state_e      state_q;
    id_ex_t      ex_q;
    id_ex_t      ex_d;
    logic [15:0] stall_q;

    logic [5:0]  opcode;
    logic [4:0]  dest;
    logic        dec_rw;
    logic        dec_mr;
    logic        dec_mw;
    logic        uses_rt;
    logic        zext;
    logic        hazard;
    logic        adv;

    function automatic logic [31:0] operand(input logic [4:0]  adr,
                                            input logic [31:0] rf_data,
                                            input logic        wb_we,
                                            input logic [4:0]  wb_adr,
                                            input logic [31:0] wb_dat);
        if (adr == 5'd0)
            return 32'd0;
        if (wb_we && wb_adr == adr)
            return wb_dat;
        return rf_data;
    endfunction

    assign opcode = inInstr[31:26];
    assign adr1   = inInstr[25:21];
    assign adr2   = inInstr[20:16];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
        dest    = 5'd0;
        dec_rw  = 1'b0;
        dec_mr  = 1'b0;
        dec_mw  = 1'b0;
        uses_rt = 1'b0;
        zext    = 1'b0;
        case (opcode)
            6'h00:        begin dest = inInstr[15:11]; dec_rw = 1'b1; uses_rt = 1'b1; end
            6'h23:        begin dest = adr2; dec_rw = 1'b1; dec_mr = 1'b1; end
            6'h2B:        begin dec_mw = 1'b1; uses_rt = 1'b1; end
            6'h08, 6'h0A: begin dest = adr2; dec_rw = 1'b1; end
            6'h0C, 6'h0D: begin dest = adr2; dec_rw = 1'b1; zext = 1'b1; end
            6'h04:        uses_rt = 1'b1;
            default:      ;
        endcase

        ex_d.pc        = inPc;
        ex_d.instr     = inInstr;
        ex_d.a         = operand(adr1, readData1, wbWrite, wbAdr, wbData);
        ex_d.b         = operand(adr2, readData2, wbWrite, wbAdr, wbData);
        ex_d.imm       = zext ? {16'd0, inInstr[15:0]} : {{16{inInstr[15]}}, inInstr[15:0]};
        ex_d.rs        = adr1;
        ex_d.rt        = adr2;
        ex_d.rd        = dest;
        ex_d.reg_write = dec_rw && (dest != 5'd0);
        ex_d.mem_read  = dec_mr;
        ex_d.mem_write = dec_mw;
    end

    // A held load whose destination is read by the incoming instruction must be separated by one bubble.
    assign hazard  = (state_q == FULL) && ex_q.mem_read && (ex_q.rt != 5'd0) &&
                     ((ex_q.rt == adr1) || (uses_rt && ex_q.rt == adr2));
    assign adv     = (state_q == EMPTY) || outReady;
    assign inReady = rst && adv && !hazard && !flush;

    // NOTE: sequential state uses non-blocking assignments only; the whole pipeline register is reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            ex_q    <= '0;
            stall_q <= 16'd0;
        end else if (flush) begin
            state_q        <= EMPTY;
            ex_q.reg_write <= 1'b0;
            ex_q.mem_read  <= 1'b0;
            ex_q.mem_write <= 1'b0;
        end else if (adv) begin
            if (inValid && !hazard) begin
                state_q <= FULL;
                ex_q    <= ex_d;
            end else begin
                state_q        <= EMPTY;
                ex_q.reg_write <= 1'b0;
                ex_q.mem_read  <= 1'b0;
                ex_q.mem_write <= 1'b0;
                if (inValid && hazard && stall_q != 16'hFFFF)
                    stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign outValid    = (state_q == FULL);
    assign outPc       = ex_q.pc;
    assign outInstr    = ex_q.instr;
    assign outA        = ex_q.a;
    assign outB        = ex_q.b;
    assign outImm      = ex_q.imm;
    assign outRs       = ex_q.rs;
    assign outRt       = ex_q.rt;
    assign outRd       = ex_q.rd;
    assign outRegWrite = ex_q.reg_write;
    assign outMemRead  = ex_q.mem_read;
    assign outMemWrite = ex_q.mem_write;
    assign stallCount  = stall_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage: decode vector table, hand-written hazard/backpressure/
// flush/reset sequences, then randomized traffic against a transaction-level model.
module tb_id_ex_operand_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        inValid;
    logic        inReady;
    logic [31:0] inInstr;
    logic [31:0] inPc;
    logic [4:0]  adr1;
    logic [4:0]  adr2;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic        wbWrite;
    logic [4:0]  wbAdr;
    logic [31:0] wbData;
    logic        outValid;
    logic        outReady;
    logic [31:0] outPc;
    logic [31:0] outInstr;
    logic [31:0] outA;
    logic [31:0] outB;
    logic [31:0] outImm;
    logic [4:0]  outRs;
    logic [4:0]  outRt;
    logic [4:0]  outRd;
    logic        outRegWrite;
    logic        outMemRead;
    logic        outMemWrite;
    logic [15:0] stallCount;

    logic [31:0] rf [32];

    int n_checks = 0;
    int n_fail   = 0;

    id_ex_operand_stage dut (
        .clk(clk), .rst(rst), .flush(flush), .inValid(inValid), .inReady(inReady),
        .inInstr(inInstr), .inPc(inPc), .adr1(adr1), .adr2(adr2),
        .readData1(readData1), .readData2(readData2),
        .wbWrite(wbWrite), .wbAdr(wbAdr), .wbData(wbData),
        .outValid(outValid), .outReady(outReady), .outPc(outPc), .outInstr(outInstr),
        .outA(outA), .outB(outB), .outImm(outImm), .outRs(outRs), .outRt(outRt), .outRd(outRd),
        .outRegWrite(outRegWrite), .outMemRead(outMemRead), .outMemWrite(outMemWrite),
        .stallCount(stallCount)
    );

    // Register file model: combinational read, register 0 deliberately holds garbage.
    assign readData1 = rf[adr1];
    assign readData2 = rf[adr2];

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, 6'h20};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rt, input int rs,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction

    // ---------------- reference model ----------------
    typedef struct {
        logic        rw;
        logic        mr;
        logic        mw;
        logic        uses_rt;
        logic [4:0]  dest;
        logic [31:0] imm;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        int   simm;
        simm      = int'($signed(ins[15:0]));
        d.rw      = 1'b0;
        d.mr      = 1'b0;
        d.mw      = 1'b0;
        d.uses_rt = 1'b0;
        d.dest    = 5'd0;
        d.imm     = 32'(simm);
        case (ins[31:26])
            6'h00: begin d.dest = ins[15:11]; d.rw = 1'b1; d.uses_rt = 1'b1; end
            6'h23: begin d.dest = ins[20:16]; d.rw = 1'b1; d.mr = 1'b1; end
            6'h2B: begin d.mw = 1'b1; d.uses_rt = 1'b1; end
            6'h08, 6'h0A: begin d.dest = ins[20:16]; d.rw = 1'b1; end
            6'h0C, 6'h0D: begin d.dest = ins[20:16]; d.rw = 1'b1; d.imm = 32'(ins[15:0]); end
            6'h04: d.uses_rt = 1'b1;
            default: ;
        endcase
        if (d.dest == 5'd0)
            d.rw = 1'b0;
        return d;
    endfunction

    function automatic logic [31:0] exp_operand(input logic [4:0] adr);
        if (adr == 5'd0) return 32'd0;
        if (wbWrite && wbAdr == adr) return wbData;
        return rf[adr];
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [5:0] ops [10] = '{6'h00, 6'h23, 6'h2B, 6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h04, 6'h02, 6'h3F};
        logic [5:0] op;
        logic [4:0] rs, rt, rd;
        op = ops[$urandom_range(9)];
        rs = 5'($urandom_range(7));
        rt = 5'($urandom_range(7));
        rd = 5'($urandom_range(7));
        if (op == 6'h00)
            return {op, rs, rt, rd, 5'd0, 6'h20};
        return {op, rs, rt, 16'($urandom)};
    endfunction

    task automatic random_phase(input int cycles);
        logic        m_valid = 1'b0;
        logic [31:0] m_pc = '0, m_instr = '0, m_a = '0, m_b = '0;
        dec_t        m_dec;
        int          m_stall = 0;
        logic        m_hazard;
        logic [31:0] ca, cb;
        dec_t        cd;
        m_dec = decode(32'hFC00_0000);
        for (int k = 0; k < 32; k++) rf[k] = $urandom;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            inValid  = ($urandom_range(3) != 0) || (c == 0);
            outReady = ($urandom_range(9) < 7) || (c == 0);
            flush    = ($urandom_range(11) == 0) && (c != 0);
            wbWrite  = 1'($urandom_range(1));
            wbAdr    = 5'($urandom_range(7));
            wbData   = $urandom;
            inPc     = $urandom;
            inInstr  = rand_instr();
            #1;
            cd = decode(inInstr);
            ca = exp_operand(inInstr[25:21]);
            cb = exp_operand(inInstr[20:16]);
            m_hazard = m_valid && m_dec.mr && (m_instr[20:16] != 5'd0) &&
                       ((m_instr[20:16] == inInstr[25:21]) ||
                        (cd.uses_rt && m_instr[20:16] == inInstr[20:16]));
            check("r_inReady", inReady, (!m_valid || outReady) && !m_hazard && !flush);
            check("r_adr1", adr1, inInstr[25:21]);
            check("r_adr2", adr2, inInstr[20:16]);
            @(posedge clk);
            if (flush) begin
                m_valid = 1'b0;
            end else if (m_valid && !outReady) begin
                // held
            end else if (inValid && !m_hazard) begin
                m_valid = 1'b1;
                m_pc    = inPc;
                m_instr = inInstr;
                m_a     = ca;
                m_b     = cb;
                m_dec   = cd;
            end else begin
                if (inValid && m_hazard && m_stall < 65535) m_stall++;
                m_valid = 1'b0;
            end
            #1;
            check("r_outValid", outValid, m_valid);
            check("r_stallCount", stallCount, 32'(m_stall));
            if (m_valid) begin
                check("r_outPc", outPc, m_pc);
                check("r_outInstr", outInstr, m_instr);
                check("r_outA", outA, m_a);
                check("r_outB", outB, m_b);
                check("r_outImm", outImm, m_dec.imm);
                check("r_outRs", outRs, m_instr[25:21]);
                check("r_outRt", outRt, m_instr[20:16]);
                check("r_outRd", outRd, m_dec.dest);
                check("r_outRegWrite", outRegWrite, m_dec.rw);
                check("r_outMemRead", outMemRead, m_dec.mr);
                check("r_outMemWrite", outMemWrite, m_dec.mw);
            end
        end
    endtask

    // ---------------- decode vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic        wb_we;
        logic [4:0]  wb_adr;
        logic [31:0] wb_data;
        logic [31:0] e_a;
        logic [31:0] e_b;
        logic [31:0] e_imm;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic        e_mr;
        logic        e_mw;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] instr, input logic wb_we, input logic [4:0] wb_adr,
                                input logic [31:0] wb_data, input logic [31:0] e_a,
                                input logic [31:0] e_b, input logic [31:0] e_imm,
                                input logic [4:0] e_rd, input logic e_rw, input logic e_mr,
                                input logic e_mw);
        vec_t v;
        v.instr = instr; v.wb_we = wb_we; v.wb_adr = wb_adr; v.wb_data = wb_data;
        v.e_a = e_a; v.e_b = e_b; v.e_imm = e_imm; v.e_rd = e_rd;
        v.e_rw = e_rw; v.e_mr = e_mr; v.e_mw = e_mw;
        return v;
    endfunction

    vec_t vecs [13];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 32; k++) rf[k] = 32'hA000_0000 | 32'(k);
        rf[0] = 32'hDEAD_BEEF;
        rf[2] = 32'd10;

        vecs[0]  = mk(32'h2001_0005,            0, 0,  0,     0,           32'hA000_0001, 32'h0000_0005, 1, 1, 0, 0);
        vecs[1]  = mk(enc_r(3, 2, 2),           1, 2,  32'h77, 32'h77,     32'h77,        32'h0000_1820, 3, 1, 0, 0);
        vecs[2]  = mk(enc_i(6'h0D, 6, 0, 16'hFFFF), 0, 0, 0,  0,           32'hA000_0006, 32'h0000_FFFF, 6, 1, 0, 0);
        vecs[3]  = mk(enc_i(6'h08, 6, 0, 16'hFFFF), 0, 0, 0,  0,           32'hA000_0006, 32'hFFFF_FFFF, 6, 1, 0, 0);
        vecs[4]  = mk(enc_r(0, 1, 2),           0, 0,  0,     32'hA000_0001, 32'd10,      32'h0000_0020, 0, 0, 0, 0);
        vecs[5]  = mk(enc_i(6'h2B, 5, 1, 16'h0008), 0, 0, 0,  32'hA000_0001, 32'hA000_0005, 32'h0000_0008, 0, 0, 0, 1);
        vecs[6]  = mk(enc_i(6'h04, 2, 1, 16'hFFFC), 0, 0, 0,  32'hA000_0001, 32'd10,      32'hFFFF_FFFC, 0, 0, 0, 0);
        vecs[7]  = mk(enc_i(6'h0C, 7, 3, 16'h8001), 0, 0, 0,  32'hA000_0003, 32'hA000_0007, 32'h0000_8001, 7, 1, 0, 0);
        vecs[8]  = mk(enc_i(6'h0A, 8, 3, 16'h8001), 0, 0, 0,  32'hA000_0003, 32'hA000_0008, 32'hFFFF_8001, 8, 1, 0, 0);
        vecs[9]  = mk(32'h0800_0040,            0, 0,  0,     0,           0,             32'h0000_0040, 0, 0, 0, 0);
        vecs[10] = mk(enc_i(6'h23, 4, 1, 16'h0000), 0, 0, 0,  32'hA000_0001, 32'hA000_0004, 32'h0000_0000, 4, 1, 1, 0);
        vecs[11] = mk(enc_r(9, 10, 0),          1, 0,  32'h55, 32'hA000_000A, 0,           32'h0000_4820, 9, 1, 0, 0);
        vecs[12] = mk(enc_r(11, 12, 13),        0, 12, 32'h99, 32'hA000_000C, 32'hA000_000D, 32'h0000_5820, 11, 1, 0, 0);

        // Reset held with random inputs.
        rst = 1'b0; flush = 1'b0; inValid = 1'b1; outReady = 1'b1;
        inInstr = $urandom; inPc = $urandom; wbWrite = 1'b1; wbAdr = 5'd3; wbData = $urandom;
        repeat (3) @(negedge clk);
        #1;
        check("rst_outValid", outValid, 0);
        check("rst_stallCount", stallCount, 0);
        check("rst_inReady", inReady, 0);
        check("rst_outA", outA, 0);
        check("rst_outRegWrite", outRegWrite, 0);
        @(negedge clk);
        rst = 1'b1;

        // Decode table, each vector accepted back-to-back.
        for (int i = 0; i < 13; i++) begin
            if (i != 0) @(negedge clk);
            inValid = 1'b1; outReady = 1'b1; flush = 1'b0;
            inInstr = vecs[i].instr; inPc = 32'h100 + 32'(4 * i);
            wbWrite = vecs[i].wb_we; wbAdr = vecs[i].wb_adr; wbData = vecs[i].wb_data;
            #1;
            check($sformatf("v%0d_inReady", i), inReady, 1);
            @(posedge clk); #1;
            check($sformatf("v%0d_outValid", i), outValid, 1);
            check($sformatf("v%0d_outPc", i), outPc, 32'h100 + 32'(4 * i));
            check($sformatf("v%0d_outInstr", i), outInstr, vecs[i].instr);
            check($sformatf("v%0d_outA", i), outA, vecs[i].e_a);
            check($sformatf("v%0d_outB", i), outB, vecs[i].e_b);
            check($sformatf("v%0d_outImm", i), outImm, vecs[i].e_imm);
            check($sformatf("v%0d_outRs", i), outRs, vecs[i].instr[25:21]);
            check($sformatf("v%0d_outRt", i), outRt, vecs[i].instr[20:16]);
            check($sformatf("v%0d_outRd", i), outRd, vecs[i].e_rd);
            check($sformatf("v%0d_outRegWrite", i), outRegWrite, vecs[i].e_rw);
            check($sformatf("v%0d_outMemRead", i), outMemRead, vecs[i].e_mr);
            check($sformatf("v%0d_outMemWrite", i), outMemWrite, vecs[i].e_mw);
        end
        wbWrite = 1'b0;

        // Load-use: lw $4 then add $5,$4,$4 -> exactly one bubble.
        @(negedge clk); inInstr = enc_i(6'h23, 4, 1, 16'h0); inPc = 32'h200;
        @(posedge clk); #1;
        check("lu_lw_valid", outValid, 1);
        @(negedge clk); inInstr = enc_r(5, 4, 4); inPc = 32'h204; #1;
        check("lu_inReady_stall", inReady, 0);
        @(posedge clk); #1;
        check("lu_bubble_valid", outValid, 0);
        check("lu_stallCount", stallCount, 1);
        @(negedge clk); #1;
        check("lu_inReady_after", inReady, 1);
        @(posedge clk); #1;
        check("lu_add_valid", outValid, 1);
        check("lu_add_instr", outInstr, enc_r(5, 4, 4));
        check("lu_add_A", outA, 32'hA000_0004);
        // Load followed by an instruction naming the load dest only as its (unused) rt.
        @(negedge clk); inInstr = enc_i(6'h23, 4, 1, 16'h0);
        @(negedge clk); inInstr = enc_i(6'h0D, 4, 1, 16'h0003); #1;
        check("lu_ori_inReady", inReady, 1);
        @(posedge clk); #1;
        check("lu_ori_valid", outValid, 1);
        // Load to $0 never stalls.
        @(negedge clk); inInstr = enc_i(6'h23, 0, 1, 16'h0);
        @(posedge clk); #1;
        check("lu0_regWrite", outRegWrite, 0);
        check("lu0_memRead", outMemRead, 1);
        @(negedge clk); inInstr = enc_r(5, 0, 0); inPc = 32'h300; #1;
        check("lu0_inReady", inReady, 1);
        @(posedge clk); #1;
        check("lu0_valid", outValid, 1);
        check("lu0_stallCount", stallCount, 1);

        // Backpressure: three cycles of outReady=0 while FULL.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); outReady = 1'b0; inInstr = enc_r(6, 1, 2); inPc = 32'h400; #1;
            check($sformatf("bp%0d_inReady", i), inReady, 0);
            @(posedge clk); #1;
            check($sformatf("bp%0d_valid", i), outValid, 1);
            check($sformatf("bp%0d_instr", i), outInstr, enc_r(5, 0, 0));
            check($sformatf("bp%0d_pc", i), outPc, 32'h300);
        end
        @(negedge clk); outReady = 1'b1; #1;
        check("bp_release_inReady", inReady, 1);
        @(posedge clk); #1;
        check("bp_release_instr", outInstr, enc_r(6, 1, 2));

        // Flush with a valid input while FULL and stalled downstream.
        @(negedge clk); flush = 1'b1; outReady = 1'b0; inInstr = enc_i(6'h08, 7, 1, 16'h1); inPc = 32'h500; #1;
        check("fl_inReady", inReady, 0);
        @(posedge clk); #1;
        check("fl_valid", outValid, 0);
        check("fl_regWrite", outRegWrite, 0);
        @(negedge clk); flush = 1'b0; outReady = 1'b1;
        @(posedge clk); #1;
        check("fl_reaccept_valid", outValid, 1);
        check("fl_reaccept_instr", outInstr, enc_i(6'h08, 7, 1, 16'h1));

        // Reset in the middle of a cycle clears immediately.
        @(negedge clk); inValid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("mr_valid", outValid, 0);
        check("mr_stallCount", stallCount, 0);
        check("mr_inReady", inReady, 0);
        check("mr_instr", outInstr, 0);
        @(negedge clk); rst = 1'b1;

        random_phase(2000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
# id_ex_operand_stage

Decode/operand-fetch stage of the MIPS pipeline, sitting between the IF/ID register and the EX stage. Each cycle it drives the register file read addresses from the incoming instruction and bypasses a same-cycle write-back. It detects load-use hazards against the instruction it currently holds and registers decoded operands into the ID/EX pipeline register under a valid/ready handshake.

## Interface
- No parameters; all widths fixed (32-bit datapath, 5-bit register addresses).
- clk  in  1  clock; all state updates on posedge
- rst  in  1  asynchronous active-low reset (asserted at 0)
- flush  in  1  synchronous squash of ID/EX contents and the current input
- inValid  in  1  IF/ID holds an instruction
- inReady  out  1  stage accepts inInstr/inPc this cycle
- inInstr  in  32  instruction word
- inPc  in  32  PC of instruction
- adr1, adr2  out  5  register file read addresses (rs = inInstr[25:21], rt = inInstr[20:16]); combinational
- readData1, readData2  in  32  register file read data, combinational from adr1/adr2
- wbWrite  in  1  write-back stage writes this cycle (same signal as register file regWrite)
- wbAdr  in  5  write-back destination
- wbData  in  32  write-back data
- outValid  out  1  ID/EX holds a valid instruction
- outReady  in  1  EX accepts ID/EX contents this cycle
- outPc, outInstr  out  32  registered copies
- outA, outB  out  32  registered rs/rt operand values
- outImm  out  32  registered immediate, extended per opcode
- outRs, outRt, outRd  out  5  registered source and destination numbers; outRd is the write destination
- outRegWrite, outMemRead, outMemWrite  out  1  registered control
- stallCount  out  16  saturating count of load-use bubbles inserted

## Operation
- Decode on opcode = inInstr[31:26]:
  - 0x00 (R-type): dest rd = [15:11], regWrite.
  - 0x23 lw: dest rt, regWrite, memRead.
  - 0x2B sw: memWrite, uses rt.
  - 0x08 addi, 0x0A slti: dest rt, regWrite, sign-extend.
  - 0x0C andi, 0x0D ori: dest rt, regWrite, zero-extend.
  - 0x04 beq: uses rt, sign-extend.
  - Any other opcode (incl. 0x02 j): all control 0.
- outImm = sign-extend of [15:0], except zero-extend for andi/ori.
- outRegWrite is forced to 0 when dest = 0.
- "Uses rt" = R-type, sw, beq. rs is always used.
- Operand select, per port:
  - Address 0 → 0.
  - Else if wbWrite && wbAdr == address → wbData.
  - Else readData.
- Load-use hazard: outValid && outMemRead && outRt != 0 && (outRt == rs || (usesRt && outRt == rt)), evaluated on inInstr.
- Forwarding from the EX/MEM stages is the EX stage's job; this block only bypasses WB.
- Load enable: adv = !outValid || outReady.
- inReady = adv && !hazard && !flush.
- FSM on ID/EX register, states EMPTY (outValid=0) and FULL (outValid=1), priority top-down:
  - flush: → EMPTY, all out* control cleared; input not accepted.
  - !adv: hold everything (FULL).
  - inValid && !hazard: capture decode and operands → FULL.
  - otherwise: → EMPTY (bubble).
- A bubble caused by hazard increments stallCount, which saturates at 0xFFFF.

## Timing
- Reset (rst=0, asynchronous):
  - outValid=0; all out* data, control and stallCount = 0.
  - inReady=0 while rst=0.
- Latency: an instruction accepted at edge N appears on out* after edge N.
- Operands are sampled at the accepting edge, including WB bypass data present in that cycle.
- adr1/adr2 follow inInstr combinationally, with no dependence on handshake.
- Load-use: exactly one bubble. After it, the held load has left ID/EX and the hazard clears, so the dependent instruction is accepted on the next edge if adv.
- Downstream stall (outReady=0 while FULL): out* stable; inReady=0.
- flush together with inValid: input dropped and outValid=0 next cycle, regardless of outReady.
- Reset mid-operation: immediate clear; first accept possible on the first edge after rst returns to 1.

## Test plan
- Reset: hold rst=0 with random inputs → outValid=0, stallCount=0, inReady=0; release, send addi $1,$0,5 (0x20010005) → next cycle outValid=1, outRd=1, outImm=5, outRegWrite=1.
- WB bypass: regfile returns 10 for $2; in the same cycle wbWrite=1, wbAdr=2, wbData=0x77, instruction add $3,$2,$2 → outA=outB=0x77.
- Load-use: lw $4,0($1), then add $5,$4,$4, outReady=1 → one cycle with outValid=0, add appears the cycle after, stallCount=1; repeat with lw $0 → no bubble.
- Extension/zero register: ori $6,$0,0xFFFF → outImm=0x0000FFFF; addi $6,$0,-1 → outImm=0xFFFFFFFF; add $0,$1,$2 → outRegWrite=0.
- Backpressure: outReady=0 for 3 cycles while FULL → out* unchanged, inReady=0; outReady=1 → next instruction loads.
- Flush: flush=1 with inValid=1 and FULL → outValid=0 next cycle, input not consumed (inReady=0 in that cycle).
